// File: rtl/motion_pkg.sv
// motion_pkg: shared state type and default tuning
// for the motion_tracker jump/duck detector.
package motion_pkg;
  typedef enum logic [1:0] {
    IDLE,
    JUMP,
    COOLDOWN
  } jump_state_t;

  localparam int WIN_DEPTH = 4;
  localparam int SUM_W     = 18;

  localparam logic signed [15:0] JUMP_THRESH  = 16'sd2400;
  localparam logic signed [15:0] JUMP_RELEASE = 16'sd1800;
  localparam logic signed [15:0] DUCK_ANGLE   = 16'sd4000;
  localparam logic signed [15:0] DUCK_RELEASE = 16'sd3000;

  localparam logic [2:0] JUMP_HOLD_SAMPLES = 3'd6;
  localparam logic [2:0] COOLDOWN_SAMPLES  = 3'd4;
  localparam logic [1:0] DUCK_SAMPLES      = 2'd3;

  localparam int STALE_CYCLES_DEFAULT = 1_000_000;
endpackage

// File: rtl/accel_window.sv
// accel_window: 4-sample moving average of signed
// acceleration, with a same-edge average for decisions.
module accel_window
  import motion_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               clear,
  input  logic signed [15:0] sample,
  output logic signed [15:0] avg,
  output logic signed [15:0] avg_next
);
  logic signed [15:0]      win [WIN_DEPTH];
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_next;

  assign sum_next = sum
                  - SUM_W'(win[WIN_DEPTH-1])
                  + SUM_W'(sample);
  // Dropping the two LSBs is an arithmetic divide by 4 (floor)
  assign avg_next = sum_next[SUM_W-1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      avg <= '0;
      for (int i = 0; i < WIN_DEPTH; i++)
        win[i] <= '0;
    end else if (shift) begin
      win[0] <= sample;
      for (int i = 1; i < WIN_DEPTH; i++)
        win[i] <= win[i-1];
      sum <= sum_next;
      avg <= avg_next;
    end else if (clear) begin
      sum <= '0;
      avg <= '0;
      for (int i = 0; i < WIN_DEPTH; i++)
        win[i] <= '0;
    end
  end
endmodule

// File: rtl/motion_tracker.sv
// motion_tracker: smoothed jump/duck detection with hold,
// cooldown, hysteresis and a stale-link watchdog.
module motion_tracker
  import motion_pkg::*;
#(
  parameter int STALE_CYCLES = STALE_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] acceleration,
  input  logic [15:0] direction,
  output logic        jumping,
  output logic        ducking,
  output logic        stale
);
  localparam int IW = $clog2(STALE_CYCLES);
  localparam logic [IW-1:0] IDLE_MAX =
    IW'(STALE_CYCLES - 1);

  logic [IW-1:0] idle_cnt;
  logic          timeout;
  logic          clear;

  assign timeout = idle_cnt == IDLE_MAX;
  // A sample arriving on the timeout cycle wins
  assign clear = timeout & ~sample_valid;

  logic signed [15:0] avg;
  logic signed [15:0] avg_next;
  logic signed [15:0] avg_now;
  logic signed [15:0] dir;

  assign dir     = $signed(direction);
  assign avg_now = sample_valid ? avg_next : avg;

  accel_window u_win (
    .clk      (clk),
    .rst      (rst),
    .shift    (sample_valid),
    .clear    (clear),
    .sample   ($signed(acceleration)),
    .avg      (avg),
    .avg_next (avg_next)
  );

  jump_state_t state, state_next;
  logic [2:0]  hold_cnt, hold_next;
  logic [2:0]  cd_cnt, cd_next;

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    cd_next    = cd_cnt;
    if (clear) begin
      state_next = IDLE;
      hold_next  = '0;
      cd_next    = '0;
    end else if (sample_valid) begin
      unique case (state)
        IDLE: begin
          if (avg_now >= JUMP_THRESH) begin
            state_next = JUMP;
            hold_next  = 3'd1;
          end
        end
        JUMP: begin
          if (hold_cnt == JUMP_HOLD_SAMPLES &&
              avg_now < JUMP_RELEASE) begin
            state_next = COOLDOWN;
            cd_next    = 3'd1;
          end else if (hold_cnt != JUMP_HOLD_SAMPLES) begin
            hold_next = hold_cnt + 3'd1;
          end
        end
        COOLDOWN: begin
          if (cd_cnt == COOLDOWN_SAMPLES)
            state_next = IDLE;
          else
            cd_next = cd_cnt + 3'd1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  logic       lean;
  logic       unlean;
  logic [1:0] lean_cnt, lean_next;
  logic       duck_raw, duck_next;

  assign lean   = dir <= -DUCK_ANGLE;
  assign unlean = dir > -DUCK_RELEASE;

  always_comb begin
    lean_next = lean_cnt;
    duck_next = duck_raw;
    if (clear) begin
      lean_next = '0;
      duck_next = 1'b0;
    end else if (sample_valid) begin
      if (!lean)
        lean_next = '0;
      else if (lean_cnt != DUCK_SAMPLES)
        lean_next = lean_cnt + 2'd1;
      if (unlean)
        duck_next = 1'b0;
      else if (lean_next == DUCK_SAMPLES)
        duck_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      cd_cnt   <= '0;
      lean_cnt <= '0;
      duck_raw <= 1'b0;
      jumping  <= 1'b0;
      ducking  <= 1'b0;
      stale    <= 1'b1;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      cd_cnt   <= cd_next;
      lean_cnt <= lean_next;
      duck_raw <= duck_next;
      jumping  <= state_next == JUMP;
      ducking  <= duck_next & (state_next != JUMP);
      if (sample_valid) begin
        idle_cnt <= '0;
        stale    <= 1'b0;
      end else if (timeout) begin
        stale <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_motion_tracker.sv
// tb_motion_tracker: directed and random stimulus checked
// every cycle against a behavioural model of the tracker.
module tb_motion_tracker;
  localparam int STALE = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] acceleration = '0;
  logic [15:0] direction = '0;
  logic        jumping;
  logic        ducking;
  logic        stale;

  int checks = 0;
  int errors = 0;

  motion_tracker #(.STALE_CYCLES(STALE)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .acceleration (acceleration),
    .direction    (direction),
    .jumping      (jumping),
    .ducking      (ducking),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  int q[$] = '{0, 0, 0, 0};
  int m_avg = 0;
  int m_mode = 0;
  int m_in_jump = 0;
  int m_cool_left = 0;
  int m_run = 0;
  int m_idle = 0;
  bit m_duck_raw = 0;
  bit m_jump = 0;
  bit m_duck = 0;
  bit m_stale = 1;

  function automatic int floor4(int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  task automatic chk(string name, logic signed [31:0] act,
                     logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q = '{0, 0, 0, 0};
    m_avg = 0;
    m_mode = 0;
    m_in_jump = 0;
    m_cool_left = 0;
    m_run = 0;
    m_duck_raw = 0;
    m_jump = 0;
    m_duck = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    int a, d;
    if (rst) begin
      model_clear();
      m_stale = 1;
      m_idle = 0;
    end else if (sample_valid) begin
      a = $signed(acceleration);
      d = $signed(direction);
      q.push_front(a);
      void'(q.pop_back());
      m_avg = floor4(q.sum());
      case (m_mode)
        0: if (m_avg >= 2400) begin
          m_mode = 1;
          m_in_jump = 1;
        end
        1: if (m_in_jump >= 6 && m_avg < 1800) begin
          m_mode = 2;
          m_cool_left = 4;
        end else begin
          m_in_jump++;
        end
        default: begin
          m_cool_left--;
          if (m_cool_left == 0) m_mode = 0;
        end
      endcase
      m_run = (d <= -4000) ? m_run + 1 : 0;
      if (d > -3000) m_duck_raw = 0;
      else if (m_run >= 3) m_duck_raw = 1;
      m_jump = (m_mode == 1);
      m_duck = m_duck_raw && !m_jump;
      m_stale = 0;
      m_idle = 0;
    end else begin
      if (m_idle < STALE) m_idle++;
      if (m_idle >= STALE) begin
        model_clear();
        m_stale = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("jumping", 32'(jumping), 32'(m_jump));
      chk("ducking", 32'(ducking), 32'(m_duck));
      chk("stale", 32'(stale), 32'(m_stale));
      chk("exclusive", 32'(jumping & ducking), 0);
    end
  end

  task automatic send(int a, int d);
    @(posedge clk);
    #1;
    sample_valid = 1'b1;
    acceleration = 16'(a);
    direction = 16'(d);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    int avg_exp[4];
    int pick;
    avg_exp = '{750, 1500, 2250, 3000};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("reset stale", 32'(stale), 1);
    chk("reset jumping", 32'(jumping), 0);
    chk("reset ducking", 32'(ducking), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle stale", 32'(stale), 1);

    send(0, 0);
    chk("first strobe stale", 32'(stale), 0);

    for (int i = 0; i < 4; i++) begin
      send(3000, 0);
      chk("ramp avg", m_avg, avg_exp[i]);
      chk("ramp jumping", 32'(jumping), (i == 3) ? 1 : 0);
    end
    for (int i = 0; i < 6; i++) begin
      send(0, 0);
      chk("hold jumping", 32'(jumping), (i == 5) ? 0 : 1);
    end
    for (int i = 0; i < 4; i++) begin
      send(9600, 0);
      chk("cooldown jumping", 32'(jumping), 0);
    end
    send(9600, 0);
    chk("retrigger jumping", 32'(jumping), 1);

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst jumping", 32'(jumping), 0);
    chk("async rst stale", 32'(stale), 1);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      send(0, -4500);
      chk("lean ducking", 32'(ducking), (i == 2) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) begin
      send(0, -3500);
      chk("band ducking", 32'(ducking), 1);
    end
    send(0, -2000);
    chk("release ducking", 32'(ducking), 0);
    send(0, -4500);
    chk("broken lean a", 32'(ducking), 0);
    send(0, -4500);
    chk("broken lean b", 32'(ducking), 0);
    send(0, 0);
    chk("broken lean c", 32'(ducking), 0);
    send(0, -4500);
    chk("broken lean d", 32'(ducking), 0);

    send(0, 0);
    repeat (3) send(0, -4500);
    chk("duck before jump", 32'(ducking), 1);
    send(9600, -4500);
    chk("priority avg", m_avg, 2400);
    chk("priority jumping", 32'(jumping), 1);
    chk("priority ducking", 32'(ducking), 0);

    repeat (STALE + 5) @(posedge clk);
    #1;
    chk("stale set", 32'(stale), 1);
    chk("stale jumping", 32'(jumping), 0);
    chk("stale ducking", 32'(ducking), 0);
    send(3000, 0);
    chk("post stale avg", m_avg, 750);
    chk("post stale jumping", 32'(jumping), 0);
    chk("post stale flag", 32'(stale), 0);

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 299) == 0) begin
        sample_valid = 1'b0;
        repeat (STALE - 3 + int'($urandom_range(0, 4)))
          @(posedge clk);
        #1;
      end
      sample_valid = $urandom_range(0, 9) < 6;
      pick = int'($urandom_range(0, 9));
      if (pick == 0)
        acceleration = 16'($urandom);
      else if (pick == 1)
        acceleration = $urandom_range(0, 1) ? 16'h8000 : 16'h7fff;
      else
        acceleration = 16'(int'($urandom_range(0, 8000)) - 1500);
      direction = 16'(int'($urandom_range(0, 10000)) - 7000);
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
